// File: rtl/corr_argmax.sv
// Streaming argmax of |din| over NUM_COL correlation samples with saturating abs and lowest-index tie-break.
// Define ARGMAX_MASK_EN to add a per-column exclusion mask for OMP support tracking.
module corr_argmax #(
  parameter int DATA_W  = 16,
  parameter int NUM_COL = 32,
  parameter int IDX_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              sel_commit,
  input  logic              mask_clear,
  output logic              busy,
  output logic              done,
  output logic              max_valid,
  output logic [IDX_W-1:0]  max_idx,
  output logic [DATA_W-1:0] max_val
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [IDX_W-1:0]  LAST_COL = IDX_W'(NUM_COL - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] best_abs_q, best_abs_d;
  logic              max_valid_q, max_valid_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;

  logic [DATA_W-1:0] din_abs;
  logic              eligible;
  logic              restart;
  logic              accept;

  // Start in DONE is deliberately dropped; the FSM returns to IDLE and sees it there.
  assign restart = start && (state_q != DONE);
  assign accept  = (state_q == SCAN) && din_valid && !start;

  always_comb begin
    if (din == MOST_NEG)     din_abs = MOST_POS;
    else if (din[DATA_W-1]) din_abs = -din;
    else                     din_abs = din;
  end

`ifdef ARGMAX_MASK_EN
  logic [NUM_COL-1:0] mask_q;

  // NOTE: the mask is a plain register vector, not a RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              mask_q <= '0;
    else if (mask_clear)                  mask_q <= '0;
    else if (sel_commit && max_valid_q)   mask_q[max_idx_q] <= 1'b1;
  end

  assign eligible = !mask_q[cnt_q];
`else
  logic unused_mask_ports;
  assign unused_mask_ports = sel_commit | mask_clear;
  assign eligible          = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (!start && din_valid && (cnt_q == LAST_COL)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    best_abs_d  = best_abs_q;
    max_valid_d = max_valid_q;
    max_idx_d   = max_idx_q;
    max_val_d   = max_val_q;
    if (restart) begin
      cnt_d       = '0;
      best_abs_d  = '0;
      max_valid_d = 1'b0;
      max_idx_d   = '0;
      max_val_d   = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      // Strict compare keeps the earliest column on ties.
      if (eligible && (!max_valid_q || (din_abs > best_abs_q))) begin
        best_abs_d  = din_abs;
        max_valid_d = 1'b1;
        max_idx_d   = cnt_q;
        max_val_d   = din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      best_abs_q  <= '0;
      max_valid_q <= 1'b0;
      max_idx_q   <= '0;
      max_val_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      best_abs_q  <= best_abs_d;
      max_valid_q <= max_valid_d;
      max_idx_q   <= max_idx_d;
      max_val_q   <= max_val_d;
    end
  end

  assign max_valid = max_valid_q;
  assign max_idx   = max_idx_q;
  assign max_val   = max_val_q;

endmodule
